// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES definitions used by the key schedule and the other round
//   stages: round count, block/word typedefs, the key-schedule FSM state
//   type and the round-constant table.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR    = 10;   // AES-128 round count
    localparam int AES_KEY_W = 128;  // key / round-key / state width

    typedef logic [31:0]          aes_word_t;
    typedef logic [AES_KEY_W-1:0] aes_block_t;
    typedef logic [3:0]           aes_ridx_t;   // round index 0..10

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // Round constant for round key idx (1..10); any other index yields 0.
    function automatic logic [7:0] aes_rcon(input aes_ridx_t idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Cyclic left rotate of a word by one byte.
    function automatic aes_word_t aes_rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
//   Forward AES S-box, purely combinational. Four copies form SubWord in the
//   key schedule; sixteen copies form SubBytes in the round datapath.
// Ports
//   byte_i  in  8  input byte
//   byte_o  out 8  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Ascending packed range: the leftmost literal byte is entry 0.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   Iterative AES-128 key expansion. After a start pulse the cipher key is
//   presented as round key 0; each accepted transfer (rk_valid & rk_ready)
//   advances to the next round key, up to key 10. A stalled consumer
//   freezes the expansion. A one-cycle done pulse follows the transfer of
//   key 10.
//
// Build option
//   AES_KEY_STORE_EN  keep every transferred round key in an 11-entry bank
//                     with a combinational random-read port, so decryption
//                     can fetch keys in reverse order.
//
// Ports
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous active-high reset
//   start     in   1    latch key_in and begin expansion (IDLE only)
//   key_in    in   128  cipher key, byte 0 in [127:120]
//   rk_ready  in   1    consumer accepts rk_out this cycle
//   rk_out    out  128  current round key (registered)
//   rk_idx    out  4    round index of rk_out, 0..10
//   rk_valid  out  1    rk_out / rk_idx valid
//   busy      out  1    expansion in progress
//   done      out  1    one-cycle pulse after key 10 is accepted
//   rd_idx    in   4    [AES_KEY_STORE_EN] bank read index
//   rd_key    out  128  [AES_KEY_STORE_EN] bank[rd_idx], 0 when rd_idx > 10
//   keys_ok   out  1    [AES_KEY_STORE_EN] all 11 keys stored since start
// ---------------------------------------------------------------------------
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,     // only 10 (AES-128) is supported
    parameter int KEY_W = AES_KEY_W   // only 128 is supported
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_idx,
    output logic             rk_valid,
    output logic             busy,
    output logic             done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic             keys_ok
`endif
);

    localparam aes_ridx_t LAST_IDX = aes_ridx_t'(NR);

    ks_state_t  state_q;
    aes_block_t rk_q;
    aes_ridx_t  rk_idx_q;
    logic       rk_valid_q;
    logic       done_q;
    logic       xfer;

    assign xfer = rk_valid_q & rk_ready;

    // -----------------------------------------------------------------------
    // Next round key: expand(rk_q, RCON[rk_idx_q + 1])
    // -----------------------------------------------------------------------
    aes_word_t  w0, w1, w2, w3;
    aes_word_t  rot_w, sub_w, t_w;
    aes_word_t  n0, n1, n2, n3;
    aes_block_t rk_next_d;
    logic [7:0] rcon;

    assign {w0, w1, w2, w3} = rk_q;
    assign rot_w            = aes_rot_word(w3);
    assign rcon             = aes_rcon(rk_idx_q + 4'd1);

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .byte_i (rot_w[8*b +: 8]),
            .byte_o (sub_w[8*b +: 8])
        );
    end

    // Each new word chains off the one just produced.
    assign t_w       = sub_w ^ {rcon, 24'h0};
    assign n0        = w0 ^ t_w;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign rk_next_d = {n0, n1, n2, n3};

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
`ifdef AES_KEY_STORE_EN
    logic keys_ok_q;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef AES_KEY_STORE_EN
            keys_ok_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        rk_q       <= key_in;
                        rk_idx_q   <= '0;
                        rk_valid_q <= 1'b1;
`ifdef AES_KEY_STORE_EN
                        keys_ok_q  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (rk_idx_q == LAST_IDX) begin
                            // Last key leaves; rk_out/rk_idx keep key 10.
                            state_q    <= IDLE;
                            rk_valid_q <= 1'b0;
                            done_q     <= 1'b1;
`ifdef AES_KEY_STORE_EN
                            keys_ok_q  <= 1'b1;
`endif
                        end else begin
                            rk_q     <= rk_next_d;
                            rk_idx_q <= rk_idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_out   = rk_q;
    assign rk_idx   = rk_idx_q;
    assign rk_valid = rk_valid_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

    // -----------------------------------------------------------------------
    // Optional round-key bank
    // -----------------------------------------------------------------------
`ifdef AES_KEY_STORE_EN
    aes_block_t bank_q [0:AES_NR];

    // NOTE: the bank is plain flops and is cleared on reset, so keys from an
    // aborted expansion can never be read back after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= AES_NR; i++) begin
                bank_q[i] <= '0;
            end
        end else if (xfer) begin
            bank_q[rk_idx_q] <= rk_q;
        end
    end

    // NOTE: rd_key gets a default before the conditional so no latch forms.
    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST_IDX) begin
            rd_key = bank_q[rd_idx];
        end
    end

    assign keys_ok = keys_ok_q;
`endif

endmodule
